// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   DEF_N         default operand width
//   MD_*          op encodings carried on input_mdctr
//   state_t/ST_*  controller state encoding
package alu_pkg;

    localparam int DEF_N = 32;

    localparam logic [1:0] MD_MULU = 2'b00;
    localparam logic [1:0] MD_MUL  = 2'b01;
    localparam logic [1:0] MD_DIVU = 2'b10;
    localparam logic [1:0] MD_DIV  = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CALC = 2'd1;
    localparam state_t ST_FIX  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/alu_muldiv_if.sv
// Request/result bundle between the execute-stage control and alu_muldiv.
//   input_start/input_a/input_b/input_mdctr  request (master -> slave)
//   out_hi/out_lo/out_valid/out_busy/out_divzero  results (slave -> master)
interface alu_muldiv_if #(
    parameter int n = 32
);
    logic         input_start;
    logic [n-1:0] input_a;
    logic [n-1:0] input_b;
    logic [1:0]   input_mdctr;
    logic [n-1:0] out_hi;
    logic [n-1:0] out_lo;
    logic         out_valid;
    logic         out_busy;
    logic         out_divzero;

    modport master (
        output input_start, input_a, input_b, input_mdctr,
        input  out_hi, out_lo, out_valid, out_busy, out_divzero
    );

    modport slave (
        input  input_start, input_a, input_b, input_mdctr,
        output out_hi, out_lo, out_valid, out_busy, out_divzero
    );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative n-bit multiply/divide unit with HI/LO results.
//   input_clk    clock
//   input_rst_n  synchronous active-low reset
//   bus          alu_muldiv_if slave: start/operands/op in, hi/lo/valid/busy/divzero out
//
// state | meaning
// IDLE  | waiting for input_start; outputs hold last result
// CALC  | n shift-add (mul) or restoring shift-subtract (div) iterations
// FIX   | sign correction, divide-by-zero override, hi/lo written
// DONE  | out_valid pulse; start ignored
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int n = DEF_N
) (
    input  logic        input_clk,
    input  logic        input_rst_n,
    alu_muldiv_if.slave bus
);

    localparam int CW = $clog2(n);
    localparam logic [CW-1:0] CNT_LOAD = CW'(n - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t        state;
    logic [CW-1:0] count;
    logic [2*n:0]  acc;      // mul: {0, hi, lo}   div: {remainder(n+1), quotient(n)}
    logic [n-1:0]  opb;      // multiplicand or divisor magnitude
    logic          is_div;
    logic          res_neg;
    logic          rem_neg;
    logic          dz;
    logic [n-1:0]  hi_q;
    logic [n-1:0]  lo_q;
    logic          divzero_q;

    // request decode, used only on the accepting edge
    logic          op_div;
    logic          op_signed;
    logic          a_neg;
    logic          b_neg;
    logic [n-1:0]  a_mag;
    logic [n-1:0]  b_mag;

    always_comb begin
        op_div    = (bus.input_mdctr == MD_DIVU) || (bus.input_mdctr == MD_DIV);
        op_signed = (bus.input_mdctr == MD_MUL)  || (bus.input_mdctr == MD_DIV);
        a_neg     = op_signed & bus.input_a[n-1];
        b_neg     = op_signed & bus.input_b[n-1];
        a_mag     = a_neg ? -bus.input_a : bus.input_a;
        b_mag     = b_neg ? -bus.input_b : bus.input_b;
    end

    // Shared n+1-bit adder: hi+multiplicand for mul, shifted remainder-divisor for div.
    logic [n:0] r_sh;
    logic [n:0] add_x;
    logic [n:0] add_y;
    logic [n:0] add_s;
    logic       add_ci;
    logic [2*n:0] acc_next;

    always_comb begin
        r_sh   = {acc[2*n-1:n], acc[n-1]};
        add_x  = acc[2*n:n];
        add_y  = {1'b0, opb};
        add_ci = 1'b0;
        if (is_div) begin
            add_x  = r_sh;
            add_y  = ~{1'b0, opb};
            add_ci = 1'b1;
        end
        add_s = add_x + add_y + {{n{1'b0}}, add_ci};

        acc_next = acc;
        if (is_div) begin
            // remainder < divisor keeps the difference inside +/-2^n, so bit n is its sign
            if (!add_s[n])
                acc_next = {add_s, acc[n-2:0], 1'b1};
            else
                acc_next = {r_sh, acc[n-2:0], 1'b0};
        end else begin
            if (acc[0])
                acc_next = {1'b0, add_s, acc[n-1:1]};
            else
                acc_next = {1'b0, acc[2*n:n], acc[n-1:1]};
        end
    end

    // Final sign fix-up. A zero divisor leaves the dividend magnitude in the
    // remainder; re-applying the dividend sign restores input_a exactly.
    logic [2*n-1:0] prod_fix;
    logic [n-1:0]   quo_fix;
    logic [n-1:0]   rem_fix;

    always_comb begin
        prod_fix = res_neg ? -acc[2*n-1:0] : acc[2*n-1:0];
        quo_fix  = dz ? '1 : (res_neg ? -acc[n-1:0] : acc[n-1:0]);
        rem_fix  = rem_neg ? -acc[2*n-1:n] : acc[2*n-1:n];
    end

    always_ff @(posedge input_clk) begin
        if (!input_rst_n) begin
            state     <= ST_IDLE;
            count     <= '0;
            acc       <= '0;
            opb       <= '0;
            is_div    <= 1'b0;
            res_neg   <= 1'b0;
            rem_neg   <= 1'b0;
            dz        <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            divzero_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.input_start) begin
                        is_div    <= op_div;
                        res_neg   <= a_neg ^ b_neg;
                        rem_neg   <= a_neg;
                        dz        <= op_div && (bus.input_b == '0);
                        opb       <= op_div ? b_mag : a_mag;
                        acc       <= {{(n+1){1'b0}}, (op_div ? a_mag : b_mag)};
                        count     <= CNT_LOAD;
                        divzero_q <= 1'b0;
                        state     <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc <= acc_next;
                    if (count == '0)
                        state <= ST_FIX;
                    else
                        count <= count - CNT_ONE;
                end
                ST_FIX: begin
                    if (is_div) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*n-1:n];
                        lo_q <= prod_fix[n-1:0];
                    end
                    divzero_q <= dz;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.out_hi      = hi_q;
    assign bus.out_lo      = lo_q;
    assign bus.out_divzero = divzero_q;
    assign bus.out_valid   = (state == ST_DONE);
    assign bus.out_busy    = (state == ST_CALC) || (state == ST_FIX);

endmodule
